// File: rtl/pio_pattern_sequencer.sv
// Avalon-MM programmable pattern sequencer: plays a small table onto out_port,
// holding each entry for DWELL+1 cycles, with optional looping and a done interrupt.
module pio_pattern_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   run_q, run_d;
    logic                   loop_q, loop_d;
    logic                   irq_en_q, irq_en_d;
    logic                   done_q, done_d;
    logic                   irq_q, irq_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]             length_q, length_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic [DATA_WIDTH-1:0]  pattern_q [DEPTH];
    logic [DATA_WIDTH-1:0]  pattern_d [DEPTH];

    logic             wr, wr_ctrl, wr_dwell, wr_len, wr_status, wr_pat, pat_hit;
    logic [IDX_W-1:0] pat_sel, next_index;
    logic [3:0]       len_eff;
    logic             start, stop, step_end, last_step, finish;

    assign wr        = chipselect & ~write_n;
    assign pat_hit   = address[3] && ({1'b0, address[2:0]} < DEPTH_L);
    assign pat_sel   = address[IDX_W-1:0];
    assign wr_ctrl   = wr && (address == 4'd0);
    assign wr_dwell  = wr && (address == 4'd1);
    assign wr_len    = wr && (address == 4'd2);
    assign wr_status = wr && (address == 4'd3);
    assign wr_pat    = wr && pat_hit;

    always_comb begin
        if (length_q == 4'd0) begin
            len_eff = 4'd1;
        end else if (length_q > DEPTH_L) begin
            len_eff = DEPTH_L;
        end else begin
            len_eff = length_q;
        end
    end

    // A stop write wins over a step boundary landing on the same edge.
    assign start      = wr_ctrl && writedata[0] && (state_q != ST_PLAY);
    assign stop       = wr_ctrl && !writedata[0] && (state_q == ST_PLAY);
    assign step_end   = (state_q == ST_PLAY) && (cnt_q == '0) && !stop;
    assign last_step  = (4'(index_q) == (len_eff - 4'd1));
    assign finish     = step_end && last_step && !loop_q;
    assign next_index = index_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_PLAY;
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (finish) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step loads read the registers as they stand, so same-cycle writes land on the next load.
    always_comb begin
        run_d     = run_q;
        loop_d    = loop_q;
        irq_en_d  = irq_en_q;
        dwell_d   = dwell_q;
        length_d  = length_q;
        pattern_d = pattern_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        out_d     = out_q;
        irq_d     = done_q & irq_en_q;

        if (wr_ctrl) begin
            run_d    = writedata[0];
            loop_d   = writedata[1];
            irq_en_d = writedata[2];
        end
        if (wr_dwell) dwell_d = writedata[DWELL_WIDTH-1:0];
        if (wr_len) length_d = writedata[3:0];
        if (wr_pat) pattern_d[pat_sel] = writedata[DATA_WIDTH-1:0];
        if (wr_status && writedata[1]) done_d = 1'b0;

        if (start) begin
            index_d = '0;
            out_d   = pattern_q[0];
            cnt_d   = dwell_q;
            done_d  = 1'b0;
        end else if ((state_q == ST_PLAY) && !stop) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (!last_step) begin
                index_d = next_index;
                out_d   = pattern_q[next_index];
                cnt_d   = dwell_q;
            end else if (loop_q) begin
                index_d = '0;
                out_d   = pattern_q[0];
                cnt_d   = dwell_q;
            end else begin
                done_d = 1'b1;
                run_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q     <= 1'b0;
            loop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            dwell_q   <= '0;
            length_q  <= '0;
            pattern_q <= '{default: '0};
            done_q    <= 1'b0;
            cnt_q     <= '0;
            index_q   <= '0;
            out_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            run_q     <= run_d;
            loop_q    <= loop_d;
            irq_en_q  <= irq_en_d;
            dwell_q   <= dwell_d;
            length_q  <= length_d;
            pattern_q <= pattern_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            index_q   <= index_d;
            out_q     <= out_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[2:0] = {irq_en_q, loop_q, run_q};
            4'd1: readdata[DWELL_WIDTH-1:0] = dwell_q;
            4'd2: readdata[3:0] = length_q;
            4'd3: begin
                readdata[0]          = (state_q == ST_PLAY);
                readdata[1]          = done_q;
                readdata[8 +: IDX_W] = index_q;
            end
            default: if (pat_hit) readdata[DATA_WIDTH-1:0] = pattern_q[pat_sel];
        endcase
    end

    assign out_port = out_q;
    assign irq      = irq_q;

endmodule

// File: doc/pio_pattern_sequencer.md
Name: pio_pattern_sequencer

Overview:
- Avalon-MM-programmable sequencer that drives an 8-bit PIO-style output port from a small pattern table, holding each entry for a programmable dwell time.
- Sits between the Nios II data master and board LEDs/GPIO, so timed output sequences play without CPU intervention.
- Optional looping; a sticky done flag and an interrupt signal the end of a one-shot sequence.

Parameters:
- DATA_WIDTH, 8, width of out_port and of each pattern entry
- DEPTH, 8, number of pattern entries (power of two, 2..8)
- DWELL_WIDTH, 16, width of the dwell counter/register

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- address  in  4  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, zero wait states
- out_port  out  DATA_WIDTH  sequenced output
- irq  out  1  interrupt, level, active-high

Behaviour:
- Reset and write qualification:
  - One clock; reset is synchronous and active-low.
  - Reset values: all registers 0, pattern table 0, out_port=0, irq=0, state IDLE.
  - A write occurs on any cycle with chipselect=1 and write_n=0. Unused bits read 0; writes to unmapped addresses are ignored.
- Register map:
  - 0 CONTROL (R/W): bit0 run, bit1 loop, bit2 irq_en.
  - 1 DWELL (R/W): [DWELL_WIDTH-1:0]. Each step holds out_port for DWELL+1 cycles.
  - 2 LENGTH (R/W): [3:0]. Effective length = 1 if LENGTH=0; DEPTH if LENGTH>DEPTH; otherwise LENGTH.
  - 3 STATUS (R; W1C on bit1): bit0 busy, bit1 done, [10:8] current index.
  - 8..8+DEPTH-1 PATTERN[i] (R/W): [DATA_WIDTH-1:0].
- State machine (states IDLE, PLAY, DONE):
  - IDLE → PLAY: on a cycle writing CONTROL with run=1.
    - Next cycle: index=0, out_port=PATTERN[0], dwell counter loaded with DWELL, done cleared, busy=1.
  - In PLAY, the counter decrements each cycle. When the counter is 0 at a clock edge, the step ends:
    - If index < len-1: index+1, load that entry and DWELL.
    - If index = len-1 and loop=1: index=0, load PATTERN[0].
    - If index = len-1 and loop=0: go to DONE, done=1, busy=0, CONTROL.run cleared, out_port holds the last entry.
  - PLAY → IDLE: on a write of CONTROL with run=0 (effective next cycle). out_port holds its current value, done is not set, busy=0.
  - Write of run=1 while in PLAY: updates loop/irq_en only; the sequence does not restart.
  - DONE → PLAY: on a run=1 write, same as from IDLE. Any other access leaves DONE.
- Latency:
  - First output change occurs 1 cycle after the run write.
  - Step k starts exactly k·(DWELL+1) cycles after step 0 starts.
- Live updates:
  - Writes to PATTERN/DWELL/LENGTH during PLAY take effect at the next step load; the current step is unaffected.
  - A PATTERN write and a load of the same entry in the same cycle: the old value is loaded.
- irq = done & irq_en, registered, updates 1 cycle after its inputs change.
- Writing 1 to STATUS bit1 clears done, unless done is being set in the same cycle, in which case set wins.
- Reset asserted mid-sequence: state, out_port and all registers return to reset values on that edge.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles → out_port=0, irq=0, readdata=0 at all addresses.
- One-shot: PATTERN[0..2]=0x01,0x02,0x04; DWELL=3; LENGTH=3; CONTROL=0x5.
  - out_port=0x01 for 4 cycles, 0x02 for 4, then 0x04 held.
  - done=1 and irq=1 one cycle later; STATUS reads 0x202.
- Loop/stop:
  - LENGTH=2, DWELL=0, CONTROL=0x3 → out_port alternates 0x01/0x02 every cycle.
  - Write CONTROL=0 → out_port freezes on its current value, busy=0, done=0.
- Clamp: LENGTH=0 with DWELL=1 → only PATTERN[0] plays for 2 cycles, then DONE. LENGTH=15 → 8 entries played.
- Live update: during step 0 of a 3-step run, write PATTERN[1]=0xAA and DWELL=5 → step 1 shows 0xAA for 6 cycles.
- W1C race and mid-run reset:
  - W1C STATUS on the exact cycle done sets → done stays 1.
  - Assert reset_n=0 mid-PLAY → out_port=0, state IDLE next cycle.
